// File: rtl/spi_init_sequencer.sv
// rtl/spi_init_sequencer.sv - LCD SPI init table walker and runtime register-write server
// Walks a ROM of register writes/delays through the SPI TX handshake, then serves single runtime writes.
module spi_init_sequencer #(
    parameter int unsigned TABLE_AW     = 5,
    parameter int unsigned DELAY_UNIT   = 50000,
    parameter int unsigned DONE_TIMEOUT = 4095,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    output logic [TABLE_AW-1:0] o_tableIndex,
    input  logic [16:0]         i_tableEntry,
    output logic                o_spiTxBegin,
    output logic [6:0]          o_spiTxAddress,
    output logic [7:0]          o_spiTxData,
    input  logic                i_spiTxBusy,
    input  logic                i_spiTxDone,
    input  logic                i_wrReq,
    input  logic [6:0]          i_wrAddress,
    input  logic [7:0]          i_wrData,
    output logic                o_wrAck,
    output logic                o_initBusy,
    output logic                o_initDone,
    output logic                o_error
);
    localparam int unsigned DW = $clog2(255 * DELAY_UNIT + 1);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [DW-1:0] LP_UNIT = DW'(DELAY_UNIT);
    localparam logic [TW-1:0] LP_TLAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SPI_REQ, S_SPI_WAIT,
        S_DELAY, S_DONE, S_USER_REQ, S_USER_WAIT, S_ERROR
    } state_t;

    state_t                r_state, w_stateNext;
    logic [TABLE_AW-1:0]   r_index, w_indexNext;
    logic [DW-1:0]         r_delay, w_delayNext;
    logic [TW-1:0]         r_timeout, w_timeoutNext;
    logic                  r_begin, w_beginNext;
    logic [6:0]            r_addr, w_addrNext;
    logic [7:0]            r_data, w_dataNext;
    logic                  r_wrAck, w_wrAckNext;
    logic                  r_autoArm, w_autoArmNext;
    logic                  w_lastEntry;

    assign w_lastEntry = (r_index == {TABLE_AW{1'b1}});

    always_comb begin
        w_stateNext   = r_state;
        w_indexNext   = r_index;
        w_delayNext   = r_delay;
        w_timeoutNext = r_timeout;
        w_beginNext   = 1'b0;
        w_addrNext    = r_addr;
        w_dataNext    = r_data;
        w_wrAckNext   = 1'b0;
        w_autoArmNext = r_autoArm;
        case (r_state)
            S_IDLE: begin
                if (i_start || r_autoArm) begin
                    w_autoArmNext = 1'b0;
                    w_indexNext   = '0;
                    w_stateNext   = S_FETCH;
                end
            end
            S_FETCH: w_stateNext = S_DECODE;
            S_DECODE: begin
                if (i_tableEntry[16]) begin
                    w_stateNext = S_DONE;
                end else if (i_tableEntry[15]) begin
                    w_delayNext = DW'(i_tableEntry[7:0]) * LP_UNIT;
                    w_stateNext = S_DELAY;
                end else begin
                    w_addrNext  = i_tableEntry[14:8];
                    w_dataNext  = i_tableEntry[7:0];
                    w_stateNext = S_SPI_REQ;
                end
            end
            S_SPI_REQ, S_USER_REQ: begin
                if (!i_spiTxBusy) begin
                    w_beginNext   = 1'b1;
                    w_timeoutNext = '0;
                    w_stateNext   = (r_state == S_SPI_REQ) ? S_SPI_WAIT : S_USER_WAIT;
                end
            end
            S_SPI_WAIT, S_USER_WAIT: begin
                if (i_spiTxDone) begin
                    if (r_state == S_USER_WAIT) begin
                        w_wrAckNext = 1'b1;
                        w_stateNext = S_DONE;
                    end else if (w_lastEntry) begin
                        w_stateNext = S_DONE;
                    end else begin
                        w_indexNext = r_index + TABLE_AW'(1);
                        w_stateNext = S_FETCH;
                    end
                end else if (r_timeout == LP_TLAST) begin
                    w_stateNext = S_ERROR;
                end else begin
                    w_timeoutNext = r_timeout + TW'(1);
                end
            end
            S_DELAY: begin
                if (r_delay != '0) begin
                    w_delayNext = r_delay - DW'(1);
                end else if (w_lastEntry) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_indexNext = r_index + TABLE_AW'(1);
                    w_stateNext = S_FETCH;
                end
            end
            S_DONE: begin
                // The ack cycle still sees the old request level, so it must not be re-accepted.
                if (i_start) begin
                    w_indexNext = '0;
                    w_stateNext = S_FETCH;
                end else if (i_wrReq && !r_wrAck) begin
                    w_addrNext  = i_wrAddress;
                    w_dataNext  = i_wrData;
                    w_stateNext = S_USER_REQ;
                end
            end
            S_ERROR: begin
                if (i_start) begin
                    w_indexNext = '0;
                    w_stateNext = S_FETCH;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_delay   <= '0;
            r_timeout <= '0;
            r_begin   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_wrAck   <= 1'b0;
            r_autoArm <= AUTO_START;
        end else begin
            r_state   <= w_stateNext;
            r_index   <= w_indexNext;
            r_delay   <= w_delayNext;
            r_timeout <= w_timeoutNext;
            r_begin   <= w_beginNext;
            r_addr    <= w_addrNext;
            r_data    <= w_dataNext;
            r_wrAck   <= w_wrAckNext;
            r_autoArm <= w_autoArmNext;
        end
    end

    assign o_tableIndex   = r_index;
    assign o_spiTxBegin   = r_begin;
    assign o_spiTxAddress = r_addr;
    assign o_spiTxData    = r_data;
    assign o_wrAck        = r_wrAck;
    assign o_initBusy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_SPI_REQ)
                         || (r_state == S_SPI_WAIT) || (r_state == S_DELAY);
    assign o_initDone     = (r_state == S_DONE) || (r_state == S_USER_REQ) || (r_state == S_USER_WAIT);
    assign o_error        = (r_state == S_ERROR);
endmodule

// File: tb/tb_spi_init_sequencer.sv
// tb/tb_spi_init_sequencer.sv - event-schedule model bench for spi_init_sequencer
module tb_spi_init_sequencer;
    localparam int DU = 10;
    localparam int DT = 100;
    localparam int M_IDLE = 0, M_INIT = 1, M_READY = 2, M_USER = 3, M_ERR = 4;
    localparam int K_NONE = 0, K_READY = 1, K_NEXT = 2, K_BEGIN = 3, K_WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_start, i_wrReq;
    logic [6:0]  i_wrAddress;
    logic [7:0]  i_wrData;
    logic        i_spiTxBusy = 1'b0, i_spiTxDone = 1'b0;
    logic [16:0] i_tableEntry = '0;
    logic [4:0]  o_tableIndex;
    logic        o_spiTxBegin, o_wrAck, o_initBusy, o_initDone, o_error;
    logic [6:0]  o_spiTxAddress;
    logic [7:0]  o_spiTxData;

    spi_init_sequencer #(.TABLE_AW(5), .DELAY_UNIT(DU), .DONE_TIMEOUT(DT), .AUTO_START(1'b1)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .o_tableIndex(o_tableIndex),
        .i_tableEntry(i_tableEntry), .o_spiTxBegin(o_spiTxBegin), .o_spiTxAddress(o_spiTxAddress),
        .o_spiTxData(o_spiTxData), .i_spiTxBusy(i_spiTxBusy), .i_spiTxDone(i_spiTxDone),
        .i_wrReq(i_wrReq), .i_wrAddress(i_wrAddress), .i_wrData(i_wrData), .o_wrAck(o_wrAck),
        .o_initBusy(o_initBusy), .o_initDone(o_initDone), .o_error(o_error)
    );

    logic [16:0] rom [32];
    always @(posedge clk) i_tableEntry <= rom[o_tableIndex];

    // Transceiver stand-in: done pulses 4 cycles after begin unless hung.
    logic       tx_hang = 1'b0;
    logic [2:0] tx_cnt = '0;
    always @(posedge clk) begin
        if (i_reset) begin
            i_spiTxBusy <= 1'b0;
            i_spiTxDone <= 1'b0;
            tx_cnt      <= '0;
        end else begin
            i_spiTxDone <= 1'b0;
            if (i_spiTxBusy) begin
                if (tx_cnt == 3'd1) begin
                    i_spiTxBusy <= 1'b0;
                    i_spiTxDone <= 1'b1;
                end
                tx_cnt <= tx_cnt - 3'd1;
            end else if (o_spiTxBegin && !tx_hang) begin
                i_spiTxBusy <= 1'b1;
                tx_cnt      <= 3'd3;
            end
        end
    end

    int total = 0, bad = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: schedules the cycle of the next observable event from the table contents.
    int m_mode = M_IDLE, m_kind = K_NONE, m_evt = 0, m_idx = 0;
    bit m_auto = 1'b0;
    logic [6:0] m_pa = '0, e_addr = '0;
    logic [7:0] m_pd = '0, e_data = '0;
    bit e_begin = 0, e_ack = 0, e_done = 0, e_err = 0;

    task automatic fetch_at(input int f);
        logic [16:0] e;
        e = rom[m_idx];
        if (e[16]) begin
            m_kind = K_READY; m_evt = f + 2;
        end else if (e[15]) begin
            m_kind = K_NEXT; m_evt = f + int'(e[7:0]) * DU + 3;
        end else begin
            m_kind = K_BEGIN; m_evt = f + 3; m_pa = e[14:8]; m_pd = e[7:0];
        end
    endtask

    task automatic go_ready();
        m_mode = M_READY; e_done = 1; m_kind = K_NONE;
    endtask

    task automatic advance_at(input int n);
        if (m_idx == 31) go_ready();
        else begin
            m_idx++;
            fetch_at(n);
        end
    endtask

    task automatic start_walk(input int n);
        m_mode = M_INIT; m_idx = 0; e_done = 0; e_err = 0;
        fetch_at(n);
    endtask

    task automatic model_step(input int n);
        bit last_ack;
        last_ack = e_ack; e_ack = 0; e_begin = 0;
        if (i_reset) begin
            m_mode = M_IDLE; m_auto = 1; m_kind = K_NONE; e_done = 0; e_err = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (i_start || m_auto) begin m_auto = 0; start_walk(n); end
            M_READY: begin
                if (i_start) start_walk(n);
                else if (i_wrReq && !last_ack) begin
                    m_mode = M_USER; m_kind = K_BEGIN; m_evt = n + 1;
                    m_pa = i_wrAddress; m_pd = i_wrData;
                end
            end
            M_ERR: if (i_start) start_walk(n);
            default: ;
        endcase
        if (m_kind == K_WAIT) begin
            if (i_spiTxDone) begin
                if (m_mode == M_USER) begin e_ack = 1; m_mode = M_READY; m_kind = K_NONE; end
                else advance_at(n);
            end else if (n == m_evt) begin
                m_mode = M_ERR; e_err = 1; e_done = 0; m_kind = K_NONE;
            end
        end else if (m_kind != K_NONE && n == m_evt) begin
            case (m_kind)
                K_READY: go_ready();
                K_NEXT:  advance_at(n);
                default: begin
                    e_begin = 1; e_addr = m_pa; e_data = m_pd; m_kind = K_WAIT; m_evt = n + DT;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step(cyc);
    end

    logic [14:0] bq[$];
    int bcyc[$], dcyc[$];
    int acount = 0, err_cyc = 0;
    bit err_q = 0;

    initial forever begin
        @(posedge clk); #2;
        chk("begin", o_spiTxBegin, e_begin);
        chk("wr_ack", o_wrAck, e_ack);
        chk("init_done", o_initDone, e_done);
        chk("error", o_error, e_err);
        chk("init_busy", o_initBusy, m_mode == M_INIT);
        if (e_begin) begin
            chk("tx_addr", o_spiTxAddress, e_addr);
            chk("tx_data", o_spiTxData, e_data);
        end
        if (o_spiTxBegin) begin
            bq.push_back({o_spiTxAddress, o_spiTxData});
            bcyc.push_back(cyc);
        end
        if (i_spiTxDone) dcyc.push_back(cyc);
        if (o_wrAck) acount++;
        if (o_error && !err_q) err_cyc = cyc;
        err_q = o_error;
    end

    task automatic wait_cond(input int which, input int lim, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = o_initDone;
                1:       ok = o_wrAck;
                default: ok = o_error;
            endcase
        end
        chk(name, ok, 1);
    endtask

    task automatic load_short();
        for (int i = 0; i < 32; i++) rom[i] = '0;
        rom[0] = {2'b00, 7'h12, 8'h34};
        rom[1] = {2'b01, 7'h00, 8'd2};
        rom[2] = {2'b00, 7'h20, 8'h01};
        rom[3] = {2'b10, 15'h0};
    endtask

    task automatic load_full();
        for (int i = 0; i < 32; i++) rom[i] = {2'b00, 7'(i), 8'(i * 5 + 1)};
    endtask

    task automatic pulse_start();
        i_start = 1; @(negedge clk); i_start = 0;
    endtask

    initial begin
        int b0, b1, a0, t0;
        bit ok;
        i_reset = 1; i_start = 0; i_wrReq = 0; i_wrAddress = '0; i_wrData = '0;
        load_short();
        repeat (3) @(negedge clk);
        chk("rst_index", o_tableIndex, 0);
        chk("rst_begin", o_spiTxBegin, 0);
        chk("rst_addr_data", {o_spiTxAddress, o_spiTxData}, 0);
        chk("rst_status", {o_initBusy, o_initDone, o_error, o_wrAck}, 0);

        // Auto-start init: write, 2-unit delay, write, END
        i_reset = 0;
        wait_cond(0, 300, "init1_reaches_done");
        chk("init1_begins", bq.size(), 2);
        chk("init1_p0", bq[0], {7'h12, 8'h34});
        chk("init1_p1", bq[1], {7'h20, 8'h01});
        chk("init1_gap", bcyc[1] - dcyc[0], 27);
        chk("init1_gap_min", (bcyc[1] - dcyc[0]) >= 21, 1);

        // Runtime write, request held through the ack cycle
        b0 = bq.size(); a0 = acount; t0 = cyc;
        i_wrAddress = 7'h55; i_wrData = 8'hAA; i_wrReq = 1;
        wait_cond(1, 50, "wr1_ack_seen");
        @(negedge clk); i_wrReq = 0;
        repeat (8) @(negedge clk);
        chk("wr1_begins", bq.size() - b0, 1);
        chk("wr1_payload", bq[b0], {7'h55, 8'hAA});
        chk("wr1_latency", bcyc[b0] - t0, 2);
        chk("wr1_acks", acount - a0, 1);
        chk("wr1_still_done", o_initDone, 1);

        // Transceiver never completes: timeout then restart via i_start
        tx_hang = 1; b0 = bq.size();
        i_wrAddress = 7'h11; i_wrData = 8'h22; i_wrReq = 1;
        wait_cond(2, 300, "timeout_error_seen");
        i_wrReq = 0;
        chk("timeout_latency", err_cyc - bcyc[b0], DT);
        chk("timeout_done_low", o_initDone, 0);
        tx_hang = 0; b0 = bq.size();
        pulse_start();
        chk("restart_clears_error", o_error, 0);
        wait_cond(0, 300, "restart_reaches_done");
        chk("restart_begins", bq.size() - b0, 2);
        chk("restart_p0", bq[b0], {7'h12, 8'h34});

        // 32 writes, no END entry
        load_full(); b0 = bq.size();
        pulse_start();
        wait_cond(0, 600, "full_reaches_done");
        repeat (20) @(negedge clk);
        chk("full_begins", bq.size() - b0, 32);
        chk("full_first", bq[b0], {7'd0, 8'd1});
        chk("full_last", bq[b0 + 31], {7'd31, 8'd156});

        // Reset during the transfer of entry 3
        b0 = bq.size(); ok = 0;
        pulse_start();
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bq.size() >= b0 + 4) ok = 1;
            else @(negedge clk);
        end
        chk("entry3_begin_seen", ok, 1);
        i_reset = 1;
        @(negedge clk);
        chk("midrst_index", o_tableIndex, 0);
        chk("midrst_addr_data", {o_spiTxAddress, o_spiTxData}, 0);
        chk("midrst_status", {o_spiTxBegin, o_initBusy, o_initDone, o_error}, 0);
        i_reset = 0; b1 = bq.size();
        wait_cond(0, 600, "midrst_reaches_done");
        chk("midrst_first", bq[b1], {7'd0, 8'd1});
        chk("midrst_begins", bq.size() - b1, 32);

        // i_start and i_wrReq together in DONE: init reruns, then the write
        load_short(); b0 = bq.size(); a0 = acount;
        i_wrAddress = 7'h66; i_wrData = 8'h77; i_wrReq = 1;
        pulse_start();
        wait_cond(1, 400, "combo_ack_seen");
        @(negedge clk); i_wrReq = 0;
        repeat (5) @(negedge clk);
        chk("combo_begins", bq.size() - b0, 3);
        chk("combo_first", bq[b0], {7'h12, 8'h34});
        chk("combo_write", bq[b0 + 2], {7'h66, 8'h77});
        chk("combo_acks", acount - a0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_init_sequencer.md
# spi_init_sequencer

Sequencer that owns the transmit side of the LCD SPI transceiver. After reset, or on request, it walks an external configuration table of register writes and delays and issues each write through the SPI transmitter's begin/busy/done handshake. Once initialisation completes, it serves single register writes from one runtime requester over the same transmitter. It sits between the top level / panel control logic and the `spi` transceiver and is the only driver of that transceiver's TX inputs.

## Interface
- `TABLE_AW`, 5: table index width (max 32 entries).
- `DELAY_UNIT`, 50000: clock cycles per delay count (1 ms at 50 MHz).
- `DONE_TIMEOUT`, 4095: maximum cycles from begin to `i_spiTxDone` before error.
- `AUTO_START`, 1: when 1, the init sequence starts automatically after reset.

- `i_clock` in 1: system clock (50 MHz).
- `i_reset` in 1: synchronous, active-high reset.
- `i_start` in 1: pulse; (re)starts the init sequence from table index 0 when in IDLE, DONE or ERROR.
- `o_tableIndex` out TABLE_AW: table read address.
- `i_tableEntry` in 17: synchronous ROM data, valid 1 cycle after `o_tableIndex`; [16]=END, [15]=DELAY, [14:8]=address, [7:0]=data.
- `o_spiTxBegin` out 1; `o_spiTxAddress` out 7; `o_spiTxData` out 8: to transceiver.
- `i_spiTxBusy` in 1; `i_spiTxDone` in 1: from transceiver.
- `i_wrReq` in 1; `i_wrAddress` in 7; `i_wrData` in 8: runtime write request, level, held until acked.
- `o_wrAck` out 1: 1-cycle pulse on the cycle after the runtime write's `i_spiTxDone`.
- `o_initBusy` out 1; `o_initDone` out 1; `o_error` out 1: status.

## Operation
- States: IDLE, FETCH, DECODE, SPI_REQ, SPI_WAIT, DELAY, DONE, USER_REQ, USER_WAIT, ERROR.
- Reset: state IDLE; all outputs 0, `o_tableIndex` 0, delay/timeout counters 0. If AUTO_START=1, the state moves to FETCH on the first cycle after reset deasserts.
- IDLE: `i_start` -> FETCH, index 0. `i_wrReq` is ignored until DONE.
- FETCH: wait 1 cycle for ROM data, then DECODE.
- DECODE: END=1 -> DONE and set `o_initDone`. DELAY=1 -> DELAY, loading counter with data×DELAY_UNIT; data=0 means zero wait. Otherwise, latch address/data onto the SPI outputs -> SPI_REQ.
- SPI_REQ: when `i_spiTxBusy`=0, assert `o_spiTxBegin` for exactly 1 cycle -> SPI_WAIT.
- SPI_WAIT: address/data are held stable. On `i_spiTxDone`, increment the index -> FETCH. If the timeout counter reaches DONE_TIMEOUT first -> ERROR.
- DELAY: the counter decrements each cycle; at 0, increment the index -> FETCH.
- Index wrap: if the index reaches 2^TABLE_AW − 1 without END, that entry is the last one executed and the state then goes to DONE.
- DONE: `o_initDone`=1. `i_wrReq`=1 -> latch request address/data -> USER_REQ.
- USER_REQ and USER_WAIT follow the same rules as SPI_REQ and SPI_WAIT. On done, pulse `o_wrAck` -> DONE. Timeout -> ERROR.
- ERROR: `o_error`=1 and `o_initDone`=0; only `i_start` or `i_reset` exits.
- `o_initBusy`=1 in FETCH, DECODE, SPI_REQ, SPI_WAIT and DELAY.
- Simultaneous events:
  - `i_start` in DONE with `i_wrReq` set: `i_start` wins, and the pending request is held unacked until DONE is reached again.
  - `i_start` during init (busy states) is ignored.
- Reset mid-transfer returns to IDLE immediately. The transceiver is reset by the same `i_reset`.

## Timing
- Table write latency: FETCH(1) + DECODE(1) + SPI_REQ(≥1) -> `o_spiTxBegin` 3 cycles after `o_tableIndex` changes, if `i_spiTxBusy`=0.
- After `i_spiTxDone`, the next entry's begin comes at the earliest 4 cycles later.
- Delay entry with data=N occupies DECODE + N×DELAY_UNIT + 1 cycles before the next FETCH.
- Runtime write: `i_wrReq` sampled in DONE -> `o_spiTxBegin` 2 cycles later at the earliest. `o_wrAck` comes 1 cycle after `i_spiTxDone`; the requester must drop or renew `i_wrReq` the cycle after ack.
- The timeout counter restarts at each `o_spiTxBegin`.

## Test plan
- Reset with AUTO_START=1; table {write 12h/34h, delay 2, write 20h/01h, END}; DELAY_UNIT=10 -> two begins with (12h,34h) then (20h,01h), ≥21 cycles apart after the first done. `o_initDone` rises after END; all outputs 0 during reset.
- In DONE, raise `i_wrReq` with 55h/AAh -> exactly one begin carrying 55h/AAh, one `o_wrAck` pulse, state back to DONE, no extra begin while `i_wrReq` is held for 1 cycle after ack.
- Transceiver model never pulses `i_spiTxDone` -> `o_error`=1 exactly DONE_TIMEOUT cycles after begin. `i_start` then restarts from index 0 and clears the error.
- Table with no END (all 32 entries writes) -> exactly 32 begins, then DONE with no wrap-around begin.
- Assert `i_reset` during SPI_WAIT of entry 3 -> outputs 0 next cycle; auto-restart issues entry 0 again.
- `i_start` and `i_wrReq` asserted together in DONE -> the init sequence reruns first, then the held write is issued and acked.
